// File: rtl/data_sram_resp_if.sv
// Data SRAM access bundle between the CPU core and its responder.
// Latency: n/a (wires only); rdata is owned by the responder.
// Backpressure: none; the responder accepts an access every cycle.
interface data_sram_resp_if;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  // Core side: issues accesses, consumes read data.
  modport master (
    output en,
    output we,
    output addr,
    output wdata,
    input  rdata
  );

  // Responder side: accepts accesses, returns read data.
  modport slave (
    input  en,
    input  we,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/data_sram_resp.sv
// Data SRAM responder: word RAM plus timer/LED/switch/numeric-display register window.
// Latency: read data registered, valid exactly one cycle after the read request.
// Backpressure: none; one access accepted every cycle, writes and reads never stall.
module data_sram_resp #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [15:0] MMIO_HI    = 16'hbfaf
) (
  input  logic               clk,
  input  logic               resetn,
  data_sram_resp_if.slave    sram,
  input  logic [15:0]        switch_in,
  output logic [15:0]        led_out,
  output logic [31:0]        num_out
);

  localparam logic [15:0] OFS_TIMER  = 16'he000;
  localparam logic [15:0] OFS_LED    = 16'hf000;
  localparam logic [15:0] OFS_SWITCH = 16'hf010;
  localparam logic [15:0] OFS_NUM    = 16'hf020;

  localparam int RAM_WORDS = 1 << ADDR_WIDTH;

  // Byte-lane merge: lanes with be[i]=1 take new data, others keep old.
  function automatic logic [31:0] lane_merge(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  logic [31:0]           mem [0:RAM_WORDS-1];
  logic [31:0]           timer;
  logic [15:0]           led_reg;
  logic [31:0]           num_reg;

  logic                  is_mmio;
  logic [15:0]           offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  acc_wr;
  logic                  acc_rd;
  logic                  ram_wr;
  logic                  timer_wr;
  logic                  led_wr;
  logic                  num_wr;
  logic [31:0]           mmio_rdata;

  // Request-cycle decode: region select, word index (aliases above ADDR_WIDTH), access type.
  always_comb begin
    is_mmio  = (sram.addr[31:16] == MMIO_HI);
    offset   = sram.addr[15:0];
    word_idx = sram.addr[ADDR_WIDTH+1:2];
    acc_wr   = sram.en && (sram.we != 4'b0000);
    acc_rd   = sram.en && (sram.we == 4'b0000);
    ram_wr   = acc_wr && !is_mmio;
    timer_wr = acc_wr && is_mmio && (offset == OFS_TIMER);
    led_wr   = acc_wr && is_mmio && (offset == OFS_LED);
    num_wr   = acc_wr && is_mmio && (offset == OFS_NUM);
  end

  // Register window read mux; unmapped offsets read as zero.
  always_comb begin
    mmio_rdata = 32'h0;
    case (offset)
      OFS_TIMER:  mmio_rdata = timer;
      OFS_LED:    mmio_rdata = {16'h0, led_reg};
      OFS_SWITCH: mmio_rdata = {16'h0, switch_in};
      OFS_NUM:    mmio_rdata = num_reg;
      default:    mmio_rdata = 32'h0;
    endcase
  end

  // RAM array with byte enables; contents are never reset, writes are blocked while in reset.
  always_ff @(posedge clk) begin
    if (resetn && ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (sram.we[i]) mem[word_idx][8*i +: 8] <= sram.wdata[8*i +: 8];
      end
    end
  end

  // Read data register: loads the pre-edge word on a read, holds otherwise.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sram.rdata <= 32'h0;
    end else if (acc_rd) begin
      sram.rdata <= is_mmio ? mmio_rdata : mem[word_idx];
    end
  end

  // Free-running timer; a write replaces the written lanes and skips that cycle's increment.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer <= 32'h0;
    end else if (timer_wr) begin
      timer <= lane_merge(timer, sram.wdata, sram.we);
    end else begin
      timer <= timer + 32'd1;
    end
  end

  // LED register holds only the low 16 bits; upper-lane writes are dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      led_reg <= 16'h0;
    end else if (led_wr) begin
      if (sram.we[0]) led_reg[7:0]  <= sram.wdata[7:0];
      if (sram.we[1]) led_reg[15:8] <= sram.wdata[15:8];
    end
  end

  // Numeric display register, full 32-bit byte-writable.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      num_reg <= 32'h0;
    end else if (num_wr) begin
      num_reg <= lane_merge(num_reg, sram.wdata, sram.we);
    end
  end

  assign led_out = led_reg;
  assign num_out = num_reg;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: reset, RAM byte writes, aliasing, registers, timer.
// Latency: checks read data exactly one cycle after each request.
// Backpressure: none exercised; the responder never stalls.
module tb_data_sram_resp;
  logic        clk;
  logic        resetn;
  logic [15:0] switch_in;
  logic [15:0] led_out;
  logic [31:0] num_out;

  int n_total;
  int n_pass;

  data_sram_resp_if sram_bus ();

  data_sram_resp #(.ADDR_WIDTH(12), .MMIO_HI(16'hbfaf)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sram      (sram_bus),
    .switch_in (switch_in),
    .led_out   (led_out),
    .num_out   (num_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sram_bus.en    = 1'b0;
    sram_bus.we    = 4'h0;
    sram_bus.addr  = 32'h0;
    sram_bus.wdata = 32'h0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    sram_bus.en    = 1'b1;
    sram_bus.we    = be;
    sram_bus.addr  = a;
    sram_bus.wdata = d;
    cyc();
    idle();
  endtask

  // Issue one read; on return rdata holds the result (one cycle after the request).
  task automatic do_read(input logic [31:0] a);
    sram_bus.en    = 1'b1;
    sram_bus.we    = 4'h0;
    sram_bus.addr  = a;
    sram_bus.wdata = 32'hffff_ffff;
    cyc();
    idle();
  endtask

  task automatic test_reset();
    resetn         = 1'b0;
    sram_bus.en    = 1'b1;
    sram_bus.we    = 4'hf;
    sram_bus.addr  = 32'hbfaf_f000;
    sram_bus.wdata = 32'hffff_ffff;
    cyc();
    cyc();
    n_total++;
    if (sram_bus.rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=%h", sram_bus.rdata, 32'h0);
    else n_pass++;
    n_total++;
    if (led_out !== 16'h0) $display("FAIL reset_led got=%h exp=%h", led_out, 16'h0);
    else n_pass++;
    n_total++;
    if (num_out !== 32'h0) $display("FAIL reset_num got=%h exp=%h", num_out, 32'h0);
    else n_pass++;
    resetn = 1'b1;
    do_read(32'hbfaf_e000);
    n_total++;
    if (!(sram_bus.rdata < 32'd4)) $display("FAIL reset_timer got=%h exp=<4", sram_bus.rdata);
    else n_pass++;
  endtask

  task automatic test_ram_bytes();
    logic [31:0] prev;
    prev = sram_bus.rdata;
    do_write(32'h0000_0100, 32'h1122_3344, 4'hf);
    do_write(32'h0000_0100, 32'haabb_ccdd, 4'b0010);
    n_total++;
    if (sram_bus.rdata !== prev) $display("FAIL write_holds_rdata got=%h exp=%h", sram_bus.rdata, prev);
    else n_pass++;
    do_read(32'h0000_0100);
    n_total++;
    if (sram_bus.rdata !== 32'h1122_cc44) $display("FAIL ram_byte_we got=%h exp=%h", sram_bus.rdata, 32'h1122_cc44);
    else n_pass++;
  endtask

  task automatic test_alias_b2b();
    do_write(32'h0000_0008, 32'hdead_beef, 4'hf);
    do_write(32'h0000_0000, 32'ha0a0_a0a0, 4'hf);
    do_write(32'h0000_0004, 32'h0404_0404, 4'hf);
    do_read(32'h0001_0008);
    n_total++;
    if (sram_bus.rdata !== 32'hdead_beef) $display("FAIL alias got=%h exp=%h", sram_bus.rdata, 32'hdead_beef);
    else n_pass++;
    sram_bus.en   = 1'b1;
    sram_bus.we   = 4'h0;
    sram_bus.addr = 32'h0000_0000;
    cyc();
    n_total++;
    if (sram_bus.rdata !== 32'ha0a0_a0a0) $display("FAIL b2b_0 got=%h exp=%h", sram_bus.rdata, 32'ha0a0_a0a0);
    else n_pass++;
    sram_bus.addr = 32'h0000_0004;
    cyc();
    n_total++;
    if (sram_bus.rdata !== 32'h0404_0404) $display("FAIL b2b_1 got=%h exp=%h", sram_bus.rdata, 32'h0404_0404);
    else n_pass++;
    sram_bus.addr = 32'h0000_0008;
    cyc();
    idle();
    n_total++;
    if (sram_bus.rdata !== 32'hdead_beef) $display("FAIL b2b_2 got=%h exp=%h", sram_bus.rdata, 32'hdead_beef);
    else n_pass++;
  endtask

  task automatic test_registers();
    switch_in = 16'h5a3c;
    do_write(32'hbfaf_f000, 32'h0001_abcd, 4'hf);
    n_total++;
    if (led_out !== 16'habcd) $display("FAIL led_out got=%h exp=%h", led_out, 16'habcd);
    else n_pass++;
    do_read(32'hbfaf_f000);
    n_total++;
    if (sram_bus.rdata !== 32'h0000_abcd) $display("FAIL led_read got=%h exp=%h", sram_bus.rdata, 32'h0000_abcd);
    else n_pass++;
    do_write(32'hbfaf_f020, 32'h1234_5678, 4'hf);
    n_total++;
    if (num_out !== 32'h1234_5678) $display("FAIL num_out got=%h exp=%h", num_out, 32'h1234_5678);
    else n_pass++;
    do_write(32'hbfaf_f010, 32'hffff_ffff, 4'hf);
    do_write(32'hbfaf_1234, 32'hffff_ffff, 4'hf);
    n_total++;
    if (led_out !== 16'habcd || num_out !== 32'h1234_5678)
      $display("FAIL ignored_writes got=%h/%h exp=%h/%h", led_out, num_out, 16'habcd, 32'h1234_5678);
    else n_pass++;
    do_read(32'hbfaf_f010);
    n_total++;
    if (sram_bus.rdata !== 32'h0000_5a3c) $display("FAIL switch_read got=%h exp=%h", sram_bus.rdata, 32'h0000_5a3c);
    else n_pass++;
    do_read(32'hbfaf_1234);
    n_total++;
    if (sram_bus.rdata !== 32'h0) $display("FAIL unmapped_read got=%h exp=%h", sram_bus.rdata, 32'h0);
    else n_pass++;
  endtask

  task automatic test_idle_hold();
    do_read(32'hbfaf_f020);
    for (int i = 0; i < 3; i++) begin
      sram_bus.addr = 32'h0000_0100 + 32'(i * 4);
      cyc();
    end
    idle();
    n_total++;
    if (sram_bus.rdata !== 32'h1234_5678) $display("FAIL idle_hold got=%h exp=%h", sram_bus.rdata, 32'h1234_5678);
    else n_pass++;
  endtask

  task automatic test_timer();
    do_write(32'hbfaf_e000, 32'hffff_fffe, 4'hf);
    do_read(32'hbfaf_e000);
    n_total++;
    if (sram_bus.rdata !== 32'hffff_fffe) $display("FAIL timer_load got=%h exp=%h", sram_bus.rdata, 32'hffff_fffe);
    else n_pass++;
    cyc();
    do_read(32'hbfaf_e000);
    n_total++;
    if (sram_bus.rdata !== 32'h0) $display("FAIL timer_wrap got=%h exp=%h", sram_bus.rdata, 32'h0);
    else n_pass++;
    do_write(32'hbfaf_e000, 32'h1234_5600, 4'hf);
    do_write(32'hbfaf_e000, 32'haabb_cc55, 4'b0001);
    do_read(32'hbfaf_e000);
    n_total++;
    if (sram_bus.rdata !== 32'h1234_5655) $display("FAIL timer_partial got=%h exp=%h", sram_bus.rdata, 32'h1234_5655);
    else n_pass++;
  endtask

  task automatic test_reset_drop();
    do_read(32'h0000_0100);
    n_total++;
    if (sram_bus.rdata !== 32'h1122_cc44) $display("FAIL pre_drop_read got=%h exp=%h", sram_bus.rdata, 32'h1122_cc44);
    else n_pass++;
    sram_bus.en   = 1'b1;
    sram_bus.we   = 4'h0;
    sram_bus.addr = 32'h0000_0100;
    cyc();
    resetn = 1'b0;
    idle();
    cyc();
    resetn = 1'b1;
    n_total++;
    if (sram_bus.rdata !== 32'h0) $display("FAIL reset_drop got=%h exp=%h", sram_bus.rdata, 32'h0);
    else n_pass++;
    n_total++;
    if (led_out !== 16'h0 || num_out !== 32'h0)
      $display("FAIL reset_regs got=%h/%h exp=0/0", led_out, num_out);
    else n_pass++;
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    switch_in = 16'h0;
    resetn    = 1'b0;
    idle();
    test_reset();
    test_ram_bytes();
    test_alias_b2b();
    test_registers();
    test_idle_hold();
    test_timer();
    test_reset_drop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder for the CPU core's data SRAM interface (en / we / addr / wdata / rdata); sits outside the core and answers every access the core issues.
- Backs a word-addressed RAM region and a small memory-mapped register window: free-running timer, LED register, numeric display register, read-only switch inputs.
- Read data returns exactly one cycle after the request, matching the core's issue-in-EX / consume-in-MEM timing.

Parameters:
- ADDR_WIDTH, 12, word-index bits of RAM (2^ADDR_WIDTH words; default 16 KB)
- MMIO_HI, 16'hbfaf, value of addr[31:16] that selects the register window instead of RAM

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- sram_en  input  1  access request this cycle
- sram_we  input  4  byte write enables; 0 = read, nonzero = write
- sram_addr  input  32  byte address; addr[1:0] ignored
- sram_wdata  input  32  write data; lane i = bits [8i+7:8i]
- sram_rdata  output  32  read data, valid the cycle after a read request
- switch_in  input  16  board switch levels, read-only register source
- led_out  output  16  LED register contents
- num_out  output  32  numeric display register contents

Behaviour:
- Every port sampled on the rising clk edge. resetn low at an edge clears all state regardless of sram_en.
- Reset values:
  - sram_rdata = 0, led_out = 0, num_out = 0, timer = 0.
  - RAM contents are not reset; they keep prior values, undefined at power-up.
- Region decode, evaluated in the request cycle:
  - addr[31:16] == MMIO_HI: register window; offset = addr[15:0].
  - Otherwise: RAM; word index = addr[ADDR_WIDTH+1:2]; higher bits ignored, so addresses alias and wrap.
- Register window map, by offset:
  - 16'he000: TIMER, RW, 32 bits.
  - 16'hf000: LED, RW, low 16 bits; upper bits read 0 and writes to them are ignored.
  - 16'hf010: SWITCH, RO, {16'b0, switch_in}; writes are ignored.
  - 16'hf020: NUM, RW, 32 bits.
  - Any other offset reads 0; writes are ignored.
- Write (sram_en=1, sram_we!=0):
  - At the edge, each byte lane with we[i]=1 is replaced by wdata lane i; other lanes are unchanged.
  - sram_rdata holds its previous value.
- Read (sram_en=1, sram_we=0):
  - At the edge, sram_rdata is loaded with the addressed word as it was before that edge.
  - Latency is exactly 1 cycle. A back-to-back read each cycle gives one result per cycle.
- Idle (sram_en=0): sram_rdata holds. No state changes except the timer.
- Read-after-write to the same address:
  - Write in cycle N, read issued in N+1: returns the new data in N+2.
  - There is no same-cycle forwarding, since only one access can exist per cycle.
- TIMER:
  - Increments by 1 every cycle with wrap-around (32'hffffffff -> 0).
  - On a write, the written lanes take wdata and the unwritten lanes take the current value.
  - The result is loaded without the +1 that cycle; the write wins over the increment.
  - A read returns the value before the edge of the request cycle.
- led_out and num_out are the register outputs directly; they change the cycle after the write edge.
- switch_in is sampled at the read edge; no synchronizer is included.
- Reset asserted while a read is outstanding: sram_rdata reads 0 in the following cycle; the result is dropped.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with sram_en=1, we=4'hf -> rdata=0, led_out=0, num_out=0; a TIMER read right after release returns a value < 4.
- RAM byte write: write 0x11223344 we=4'hf to 0x00000100, then we=4'b0010 with wdata 0xAABBCCDD, then read 0x00000100 -> rdata=0x1122CC44 exactly one cycle after the read.
- Aliasing and back-to-back reads:
  - Write 0xDEADBEEF to 0x00000008, read 0x00010008 (ADDR_WIDTH=12) -> 0xDEADBEEF.
  - Read 0x0, 0x4, 0x8 on consecutive cycles -> three results on consecutive cycles, in order.
- Registers and idle hold:
  - Write 0x0001ABCD to 0xbfaff000 -> led_out=0xABCD next cycle; readback = 0x0000ABCD.
  - Write 0x12345678 to 0xbfaff020 -> num_out=0x12345678.
  - Write to 0xbfaff010 or 0xbfaf1234 -> no change; reads return switch_in and 0 respectively.
  - sram_en=0 for 3 cycles -> rdata unchanged.
- Timer:
  - Write 0xfffffffe to 0xbfafe000 in cycle N; read in N+1 -> 0xfffffffe; read in N+3 -> 0x00000000 (wrap).
  - A partial write we=4'b0001 with wdata 0x55 replaces only the low byte and suppresses that cycle's increment.
